// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and one-entry fetch register feeding decode
// Fetches from a combinational instruction memory, handles stalls, redirects and HALT.
module fetch_sequencer #(
    parameter int              PC_WIDTH    = 16,
    parameter int              INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OPCODE = 4'hD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [PC_WIDTH-1:0]    pc_current,
    input  logic [INSTR_WIDTH-1:0] imem_instr,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc,
    input  logic                   id_ready,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   running,
    output logic                   halted,
    output logic [15:0]            instr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(2);
    localparam logic [PC_WIDTH-1:0] PC_ALIGN = {{(PC_WIDTH-1){1'b1}}, 1'b0};

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic                   if_valid_q, if_valid_d;
    logic [INSTR_WIDTH-1:0] if_instr_q, if_instr_d;
    logic [PC_WIDTH-1:0]    if_pc_q, if_pc_d;
    logic [15:0]            count_q, count_d;

    logic transfer;
    logic slot_free;
    logic is_halt_word;

    assign transfer     = if_valid_q & id_ready;
    assign slot_free    = ~if_valid_q | id_ready;
    assign is_halt_word = (imem_instr[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        count_d    = count_q;

        // A transfer still counts when a redirect flushes the register on the same edge.
        if (transfer && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (slot_free) begin
                    if_valid_d = 1'b0;
                end
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = RESET_PC;
                    count_d = 16'd0;
                end
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc & PC_ALIGN;
                    if_valid_d = 1'b0;
                end else if (slot_free) begin
                    if_instr_d = imem_instr;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + PC_STEP;
                    if (is_halt_word) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    state_d    = S_FETCH;
                    pc_d       = redirect_pc & PC_ALIGN;
                    if_valid_d = 1'b0;
                end else begin
                    if (slot_free) begin
                        if_valid_d = 1'b0;
                    end
                    if (start) begin
                        state_d = S_FETCH;
                        pc_d    = RESET_PC;
                        count_d = 16'd0;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                if_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            count_q    <= count_d;
        end
    end

    assign pc_current  = pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign instr_count = count_q;
    assign running     = (state_q == S_FETCH);
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - vector table, directed corner sequences and randomized scoreboard
// The scoreboard predicts the delivered instruction stream, not the pipeline.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] pc_current;
    logic [15:0] imem_instr;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        running;
    logic        halted;
    logic [15:0] instr_count;

    logic [15:0] mem [16];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[pc_current[4:1]];

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .pc_current     (pc_current),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .running        (running),
        .halted         (halted),
        .instr_count    (instr_count)
    );

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [15:0] rpc;
        logic        ev;
        logic [15:0] epc;
        logic [15:0] einstr;
        logic [15:0] epcc;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst            = 1'b0;
        start          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
    endtask

    task automatic do_reset_check(input string tag);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk({tag, "_valid"},   {31'd0, if_valid}, 32'd0);
        chk({tag, "_instr"},   {16'd0, if_instr}, 32'd0);
        chk({tag, "_ifpc"},    {16'd0, if_pc}, 32'd0);
        chk({tag, "_pc"},      {16'd0, pc_current}, 32'd0);
        chk({tag, "_count"},   {16'd0, instr_count}, 32'd0);
        chk({tag, "_flags"},   {30'd0, running, halted}, 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_running", {31'd0, running}, 32'd1);
        chk("start_pc", {16'd0, pc_current}, 32'd0);
    endtask

    // Random-phase scoreboard state
    logic [15:0] exp_next;
    logic [15:0] m_count;
    logic        m_halt;

    initial begin
        logic        pre_valid;
        logic [15:0] pre_pc;
        logic [15:0] pre_instr;
        logic        saw_halt;

        for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0]  = 16'h0400;
        mem[1]  = 16'h0441;
        mem[2]  = 16'h2050;
        mem[3]  = 16'h1280;
        mem[4]  = 16'h3050;
        mem[14] = 16'hD000;
        mem[15] = 16'hF00F;

        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0400, 16'h0002, 16'd0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0441, 16'h0004, 16'd1};
        tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h2050, 16'h0006, 16'd2};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h2050, 16'h0006, 16'd2};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h2050, 16'h0006, 16'd2};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h2050, 16'h0006, 16'd2};
        tbl[6]  = '{1'b1, 1'b1, 16'h0009, 1'b0, 16'h0000, 16'h0000, 16'h0008, 16'd3};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 16'h3050, 16'h000A, 16'd3};
        tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h000A, 16'h1005, 16'h000C, 16'd4};
        tbl[9]  = '{1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'h0000, 16'hFFFE, 16'd4};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 16'hF00F, 16'h0000, 16'd4};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 16'hF00F, 16'h0000, 16'd4};
        tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0400, 16'h0002, 16'd5};

        idle_inputs();
        do_reset_check("reset");
        do_start();

        for (int i = 0; i < 13; i++) begin
            id_ready       = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            step();
            chk($sformatf("tbl%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_ifpc", i),  {16'd0, if_pc},    {16'd0, tbl[i].epc});
                chk($sformatf("tbl%0d_instr", i), {16'd0, if_instr}, {16'd0, tbl[i].einstr});
            end
            chk($sformatf("tbl%0d_pc", i),    {16'd0, pc_current},  {16'd0, tbl[i].epcc});
            chk($sformatf("tbl%0d_count", i), {16'd0, instr_count}, {16'd0, tbl[i].ecnt});
        end
        redirect_valid = 1'b0;

        // Straight-line run to the HALT word
        idle_inputs();
        do_reset_check("reset2");
        do_start();
        id_ready = 1'b1;
        saw_halt = 1'b0;
        for (int c = 0; c < 40 && !saw_halt; c++) begin
            step();
            if (if_valid && if_instr != mem[if_pc[4:1]]) chk("line_word", {16'd0, if_instr}, {16'd0, mem[if_pc[4:1]]});
            if (halted) saw_halt = 1'b1;
        end
        chk("line_halt_seen", {31'd0, saw_halt}, 32'd1);
        chk("line_halt_ifpc", {16'd0, if_pc}, 32'h001C);
        chk("line_halt_instr", {16'd0, if_instr}, 32'hD000);
        step();
        chk("line_count", {16'd0, instr_count}, 32'd15);
        chk("line_flush", {31'd0, if_valid}, 32'd0);
        chk("line_flags", {30'd0, running, halted}, 32'd1);
        step();
        step();
        chk("line_pc_hold", {16'd0, pc_current}, 32'h001E);
        chk("line_count_hold", {16'd0, instr_count}, 32'd15);

        // Redirect out of HALT
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0005;
        step();
        redirect_valid = 1'b0;
        chk("hredir_running", {31'd0, running}, 32'd1);
        chk("hredir_pc", {16'd0, pc_current}, 32'h0004);
        chk("hredir_valid", {31'd0, if_valid}, 32'd0);
        step();
        chk("hredir_ifpc", {16'd0, if_pc}, 32'h0004);
        chk("hredir_instr", {16'd0, if_instr}, 32'h2050);

        // Reset during a stall, then restart
        id_ready = 1'b0;
        step();
        step();
        do_reset_check("midrst");
        do_start();
        id_ready = 1'b1;
        step();
        chk("restart_ifpc", {16'd0, if_pc}, 32'h0000);
        chk("restart_instr", {16'd0, if_instr}, 32'h0400);

        // Randomized run against the delivered-stream scoreboard
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(0, 7) == 0) mem[i][15:12] = 4'hD;
            else if (mem[i][15:12] == 4'hD) mem[i][15:12] = 4'h5;
        end
        start = 1'b1;
        step();
        start    = 1'b0;
        exp_next = 16'h0000;
        m_count  = 16'd0;
        m_halt   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            id_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 16'($urandom);
            start          = m_halt && !redirect_valid && ($urandom_range(0, 4) == 0);
            pre_valid = if_valid;
            pre_pc    = if_pc;
            pre_instr = if_instr;
            step();
            if (pre_valid && id_ready) begin
                chk("rnd_order", {16'd0, pre_pc}, {16'd0, exp_next});
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                exp_next = pre_pc + 16'd2;
                if (pre_instr[15:12] == 4'hD) m_halt = 1'b1;
            end
            if (redirect_valid) begin
                exp_next = redirect_pc & 16'hFFFE;
                m_halt   = 1'b0;
            end
            if (start) begin
                exp_next = 16'h0000;
                m_count  = 16'd0;
                m_halt   = 1'b0;
            end
            if (pre_valid && !id_ready && !redirect_valid) begin
                chk("rnd_hold_pc", {16'd0, if_pc}, {16'd0, pre_pc});
                chk("rnd_hold_instr", {16'd0, if_instr}, {16'd0, pre_instr});
            end
            if (if_valid) chk("rnd_word", {16'd0, if_instr}, {16'd0, mem[if_pc[4:1]]});
            if (m_halt) begin
                chk("rnd_halted", {31'd0, halted}, 32'd1);
                chk("rnd_halt_empty", {31'd0, if_valid}, 32'd0);
            end
            chk("rnd_count", {16'd0, instr_count}, {16'd0, m_count});
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
